// File: rtl/acc_write_arbiter.sv
// Two-requester write-port arbiter for the 32-bit accumulator register.
// Round-robin on ties, registered one-cycle CE/WE strobe, per-requester ack pulse.
module acc_write_arbiter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] din0,
    output logic             ack0,
    input  logic             req1,
    input  logic [WIDTH-1:0] din1,
    output logic             ack1,
    output logic             ram_ce,
    output logic             ram_we,
    output logic [WIDTH-1:0] ram_di,
    output logic             busy,
    output logic             last_grant,
    output logic [CNT_W-1:0] wr_count
);

    typedef enum logic [1:0] {StIdle, StWrite, StAck} state_e;

    state_e             r_state, w_state_d;
    logic [WIDTH-1:0]   r_hold, w_hold_d;
    logic               r_winner, w_winner_d;
    logic               r_last_grant, w_last_grant_d;
    logic               r_ack0, w_ack0_d;
    logic               r_ack1, w_ack1_d;
    logic               r_strobe, w_strobe_d;
    logic [CNT_W-1:0]   r_count, w_count_d;
    logic               w_pick;

    // Lone requester wins outright; on a tie the side not granted last time wins.
    assign w_pick = (req0 && req1) ? ~r_last_grant : req1;

    always_comb begin
        w_state_d      = r_state;
        w_hold_d       = r_hold;
        w_winner_d     = r_winner;
        w_last_grant_d = r_last_grant;
        w_ack0_d       = 1'b0;
        w_ack1_d       = 1'b0;
        w_strobe_d     = 1'b0;
        w_count_d      = r_count;
        unique case (r_state)
            StIdle: begin
                if (req0 || req1) begin
                    w_winner_d = w_pick;
                    w_hold_d   = w_pick ? din1 : din0;
                    w_strobe_d = 1'b1;
                    w_state_d  = StWrite;
                end
            end
            StWrite: begin
                w_ack0_d       = ~r_winner;
                w_ack1_d       = r_winner;
                w_last_grant_d = r_winner;
                w_count_d      = r_count + CNT_W'(1);
                w_state_d      = StAck;
            end
            StAck: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= StIdle;
            r_hold       <= '0;
            r_winner     <= 1'b0;
            r_last_grant <= 1'b1;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_strobe     <= 1'b0;
            r_count      <= '0;
        end else begin
            r_state      <= w_state_d;
            r_hold       <= w_hold_d;
            r_winner     <= w_winner_d;
            r_last_grant <= w_last_grant_d;
            r_ack0       <= w_ack0_d;
            r_ack1       <= w_ack1_d;
            r_strobe     <= w_strobe_d;
            r_count      <= w_count_d;
        end
    end

    assign ack0       = r_ack0;
    assign ack1       = r_ack1;
    assign ram_ce     = r_strobe;
    assign ram_we     = r_strobe;
    assign ram_di     = r_hold;
    assign busy       = (r_state != StIdle);
    assign last_grant = r_last_grant;
    assign wr_count   = r_count;

endmodule

// File: tb/tb_acc_write_arbiter.sv
// Randomized bench for acc_write_arbiter against a grant-timestamp reference model.
module tb_acc_write_arbiter;

    localparam int W  = 32;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, req1;
    logic [W-1:0]  din0, din1;
    logic          ack0, ack1, ram_ce, ram_we, busy, last_grant;
    logic [W-1:0]  ram_di;
    logic [CW-1:0] wr_count;

    int n_checks = 0;
    int n_errors = 0;

    // Model: a write is a grant at edge g; strobe follows edge g, ack follows edge g+1,
    // and the next request can be taken at edge g+3.
    int          cyc;
    bit          m_have;
    int          m_g;
    bit          m_win;
    logic [31:0] m_hold;
    bit          m_last;
    int          m_cnt;

    always #5 clk = ~clk;

    acc_write_arbiter #(
        .WIDTH (W),
        .CNT_W (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req0       (req0),
        .din0       (din0),
        .ack0       (ack0),
        .req1       (req1),
        .din1       (din1),
        .ack1       (ack1),
        .ram_ce     (ram_ce),
        .ram_we     (ram_we),
        .ram_di     (ram_di),
        .busy       (busy),
        .last_grant (last_grant),
        .wr_count   (wr_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_have = 1'b0;
        m_hold = '0;
        m_last = 1'b1;
        m_cnt  = 0;
    endtask

    task automatic model_step();
        bit free;
        free = !m_have || (cyc >= m_g + 3);
        if (m_have && cyc == m_g + 1) begin
            m_last = m_win;
            m_cnt  = (m_cnt + 1) % (1 << CW);
        end
        if (free && (req0 || req1)) begin
            m_win  = (req0 && req1) ? !m_last : req1;
            m_hold = m_win ? din1 : din0;
            m_g    = cyc;
            m_have = 1'b1;
        end
    endtask

    task automatic check_outputs();
        bit w, a;
        w = m_have && (cyc == m_g);
        a = m_have && (cyc == m_g + 1);
        chk("ram_ce", 32'(ram_ce), 32'(w));
        chk("ram_we", 32'(ram_we), 32'(w));
        chk("ram_di", ram_di, m_hold);
        chk("ack0", 32'(ack0), 32'(a && !m_win));
        chk("ack1", 32'(ack1), 32'(a && m_win));
        chk("busy", 32'(busy), 32'(w || a));
        chk("last_grant", 32'(last_grant), 32'(m_last));
        chk("wr_count", 32'(wr_count), 32'(m_cnt));
    endtask

    task automatic cycle();
        @(posedge clk);
        cyc++;
        if (!rst) model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        check_outputs();
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        cyc  = 0;
        m_g  = 0;
        m_win = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        din0 = '0;
        din1 = '0;
        rst  = 1'b1;
        model_reset();
        #2;
        check_outputs();
        cycle();
        cycle();
        rst = 1'b0;

        // Single request from requester 0.
        req0 = 1'b1;
        din0 = 32'h0000_0007;
        cycle();
        req0 = 1'b0;
        din0 = $urandom;
        repeat (4) cycle();

        // Tie from reset with both sides holding: A, B, A, B ...
        do_reset();
        req0 = 1'b1;
        req1 = 1'b1;
        din0 = 32'h0000_000A;
        din1 = 32'h0000_000B;
        repeat (10) cycle();
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (3) cycle();

        // Early drop: one-cycle pulse, data changed right after the grant.
        req1 = 1'b1;
        din1 = 32'h0000_0055;
        cycle();
        req1 = 1'b0;
        din1 = 32'hDEAD_BEEF;
        repeat (4) cycle();

        // Randomized traffic with varying request density and occasional resets mid-write.
        for (int i = 0; i < 3000; i++) begin
            int p;
            p    = (i / 500) * 18 + 5;
            req0 = ($urandom_range(0, 99) < p);
            req1 = ($urandom_range(0, 99) < p);
            din0 = $urandom;
            din1 = $urandom;
            cycle();
            if (m_have && cyc == m_g && $urandom_range(0, 29) == 0) begin
                do_reset();
            end
        end

        req0 = 1'b0;
        req1 = 1'b0;
        repeat (4) cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
